// File: rtl/my_alu_pkg.sv
// Shared ALU definitions: divider FSM states, default datapath width and
// the quotient reported for a divide-by-zero.
package my_alu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/my_div_step.sv
// One restoring-division iteration: shift {rem,quot} left by one, then
// subtract the divisor from the remainder when it fits.
module my_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        // The shifted remainder carries one extra bit so the compare never loses the MSB.
        shifted   = {rem, quot[WIDTH-1]};
        diff      = shifted - {1'b0, divisor};
        fits      = (shifted >= {1'b0, divisor});
        rem_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/my_sequential_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define MY_DIV_SIGNED_EN to add the DivSigned port and the FIX sign-correction state.
module my_sequential_divider
    import my_alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MY_DIV_SIGNED_EN
    input  logic             DivSigned,
`endif
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    div_state_t       state, next_state;
    logic [WIDTH-1:0] rem_q, quot_q, div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] step_rem, step_quot;
    logic [WIDTH-1:0] op_a, op_b;
    logic             b_zero;
    logic             last_step;
    logic             to_fix;

`ifdef MY_DIV_SIGNED_EN
    logic sgn_q, neg_q, neg_r;

    always_comb begin
        op_a   = (DivSigned && A[WIDTH-1]) ? -A : A;
        op_b   = (DivSigned && B[WIDTH-1]) ? -B : B;
        to_fix = sgn_q;
    end
`else
    always_comb begin
        op_a   = A;
        op_b   = B;
        to_fix = 1'b0;
    end
`endif

    assign b_zero    = (B == '0);
    assign last_step = (cnt_q == '0);

    my_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quot     (quot_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .quot_next(step_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    next_state = to_fix ? FIX : DONE;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Result registers are written on the edge that enters DONE, so they are
    // already valid while done is high and then hold until the next result.
    always_ff @(posedge clk) begin
        if (reset) begin
            Quot        <= '0;
            Rem         <= '0;
            div_by_zero <= 1'b0;
            rem_q       <= '0;
            quot_q      <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
`ifdef MY_DIV_SIGNED_EN
            sgn_q       <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_zero) begin
                            Quot        <= WIDTH'(DIV_ZERO_QUOT);
                            Rem         <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            rem_q  <= '0;
                            quot_q <= op_a;
                            div_q  <= op_b;
                            cnt_q  <= CNT_W'(WIDTH - 1);
`ifdef MY_DIV_SIGNED_EN
                            sgn_q  <= DivSigned;
                            neg_q  <= DivSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r  <= DivSigned && A[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    rem_q  <= step_rem;
                    quot_q <= step_quot;
                    cnt_q  <= cnt_q - 1'b1;
                    if (last_step && !to_fix) begin
                        Quot        <= step_quot;
                        Rem         <= step_rem;
                        div_by_zero <= 1'b0;
                    end
                end
`ifdef MY_DIV_SIGNED_EN
                FIX: begin
                    Quot        <= neg_q ? -quot_q : quot_q;
                    Rem         <= neg_r ? -rem_q : rem_q;
                    div_by_zero <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_my_sequential_divider.sv
// Self-checking bench for my_sequential_divider; follows MY_DIV_SIGNED_EN
// to connect DivSigned and to enable signed expectations.
module tb_my_sequential_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        div_signed;
    logic [31:0] Quot;
    logic [31:0] Rem;
    logic        busy;
    logic        done;
    logic        div_by_zero;

`ifdef MY_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    my_sequential_divider #(
        .WIDTH(32),
        .CNT_W(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
`ifdef MY_DIV_SIGNED_EN
        .DivSigned  (div_signed),
`endif
        .Quot       (Quot),
        .Rem        (Rem),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic division with the documented special cases.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
        dz = (b == 32'd0);
        if (dz) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (!sgn) begin
            q = a / b; r = a % b; lat = 33;
        end else begin
            lat = 34;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        A = a; B = b; div_signed = sgn; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; div_signed = 1'($urandom);
    endtask

    task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit sgn, input bit poke, input bit b2b,
                             input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] eq, er;
        logic        edz;
        int          elat;
        int          cyc;
        bit          busy_ok;
        model(a, b, sgn && SIGNED_EN, eq, er, edz, elat);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && cyc == 5) begin
                start = 1'b1; A = 32'd1; B = 32'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, cyc, elat);
        check({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
        check({tag, " quot"}, Quot, eq);
        check({tag, " rem"}, Rem, er);
        check({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        if (b2b) begin
            A = na; B = nb; div_signed = 1'b0; start = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " idle_after"}, {31'd0, busy}, 32'd0);
        check({tag, " quot_held"}, Quot, eq);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input bit sgn);
        issue(a, b, sgn);
        finish_op(tag, a, b, sgn, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          sel;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; div_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst quot", Quot, 32'd0);
        check("rst rem", Rem, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst dz", {31'd0, div_by_zero}, 32'd0);

        run("d100_7", 32'd100, 32'd7, 1'b0);
        run("d6_8", 32'd6, 32'd8, 1'b0);
        run("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        run("d5_0", 32'd5, 32'd0, 1'b0);
        run("d0_5", 32'd0, 32'd5, 1'b0);
        run("d7_7", 32'd7, 32'd7, 1'b0);
        run("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run("d1_max", 32'd1, 32'hFFFF_FFFF, 1'b0);
        run("dmsb_3", 32'h8000_0001, 32'd3, 1'b0);

        issue(32'd100, 32'd7, 1'b0);
        finish_op("ignore_start", 32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);

        issue(32'd1000, 32'd33, 1'b0);
        finish_op("b2b_first", 32'd1000, 32'd33, 1'b0, 1'b0, 1'b1, 32'd77, 32'd10);
        run("b2b_second", 32'd77, 32'd10, 1'b0);

        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst quot", Quot, 32'd0);
        check("midrst rem", Rem, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        run("d9_3", 32'd9, 32'd3, 1'b0);

        if (SIGNED_EN) begin
            run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
            run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
            run("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
            run("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
            run("s_unsigned_sel", 32'hFFFF_FFF9, 32'd2, 1'b0);
        end

        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)     rb = 32'd0;
            else if (sel < 5) rb = $urandom_range(1, 1000);
            else              rb = $urandom;
            run("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/my_sequential_divider.md
# my_sequential_divider

Multi-cycle 32-bit integer divider for the ALU datapath. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per cycle using a restoring shift-and-subtract loop. At each step a single compare-and-subtract (remainder ≥ divisor) sets the quotient bit. It sits beside the combinational ALU as the slow-path responder for divide and remainder operations, and reports completion with a one-cycle done pulse.

## Interface
- Parameters:
  - WIDTH, 32, operand/result width
  - CNT_W, 5, iteration counter width (log2 WIDTH)
- Ports:
  - clk  input  1  system clock, all state on rising edge
  - reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
  - start  input  1  request; sampled only in IDLE
  - A  input  WIDTH  dividend
  - B  input  WIDTH  divisor
  - DivSigned  input  1  signed operation select (present only with MY_DIV_SIGNED_EN)
  - Quot  output  WIDTH  quotient, held until next accepted start
  - Rem  output  WIDTH  remainder, held until next accepted start
  - busy  output  1  high in every state except IDLE
  - done  output  1  one-cycle completion pulse
  - div_by_zero  output  1  valid with done; held with results

## Operation
- States: IDLE, CALC, FIX (signed build only), DONE.
- IDLE:
  - On start=1, latch A and B.
  - If B==0, go to DONE with Quot=32'hFFFFFFFF, Rem=A, div_by_zero=1.
  - Otherwise clear the partial remainder, load the quotient register with the dividend, set the counter to 31, and go to CALC.
- CALC, per cycle:
  - Shift {rem,quot} left by 1.
  - If shifted rem ≥ B (unsigned 33-bit compare, no overflow loss), rem = rem − B and quot[0]=1; else quot[0]=0.
  - Decrement the counter. After the step with counter==0, go to FIX if signed, else DONE.
- FIX: apply the sign correction described under Configuration, then go to DONE.
- DONE:
  - Update Quot, Rem and div_by_zero.
  - done=1 for exactly one cycle, then return to IDLE.
- start is ignored while busy=1; no queueing.
- Mid-operation reset: returns to IDLE next edge; partial work is discarded.
- Reset values: Quot=0, Rem=0, busy=0, done=0, div_by_zero=0.

## Timing
- start accepted at edge N; the CALC state occupies edges N+1..N+32.
- Unsigned: done is high during cycle N+33, and results are valid from that edge onward.
- Signed build with DivSigned=1: one extra FIX cycle, so done is high during cycle N+34.
- Divide-by-zero: done is high during cycle N+1 and no CALC cycles are used.
- Back-to-back: start may be asserted in the same cycle that done is high. It is not accepted, because the block is in DONE; it is accepted in the following IDLE cycle.
- Inputs A and B are read only at the accept edge and may change freely afterwards.

## Configuration
- MY_DIV_SIGNED_EN defined:
  - The DivSigned port exists.
  - When DivSigned=1, operands are converted to magnitudes at accept.
  - In FIX, the quotient is negated if A[31]^B[31], and the remainder takes the sign of A.
  - Divide-by-zero output is unchanged (Quot=all ones, Rem=A).
  - Overflow case A=32'h80000000, B=32'hFFFFFFFF returns Quot=32'h80000000, Rem=0.
- MY_DIV_SIGNED_EN undefined: unsigned only; no DivSigned port, no FIX state, latency is always 33.

## Structure
- Shared package my_alu_pkg holds:
  - state enum (IDLE/CALC/FIX/DONE)
  - WIDTH default
  - DIV_ZERO_QUOT constant (all ones)
- One sub-module is natural: my_div_step.
  - Combinational; inputs {rem, quot, B}.
  - Outputs the next {rem, quot} after one shift/compare/subtract.
  - Keeps the FSM and datapath separate.

## Test plan
- A=100, B=7, start one cycle → done in cycle 33, Quot=14, Rem=2, div_by_zero=0, busy high for cycles 1..33.
- A=6, B=8 → Quot=0, Rem=6.
- A=32'hFFFFFFFF, B=1 → Quot=32'hFFFFFFFF, Rem=0.
- A=5, B=0 → done one cycle after accept, Quot=32'hFFFFFFFF, Rem=5, div_by_zero=1.
- A=100, B=7, reset at cycle 10 then start with A=9, B=3 → outputs zero after reset, then Quot=3, Rem=0. A start pulse during busy has no effect.
- Signed build: A=−7 (32'hFFFFFFF9), B=2, DivSigned=1 → done in cycle 34, Quot=32'hFFFFFFFD, Rem=32'hFFFFFFFF.
